// File: rtl/reg_file_core.sv
// 16-bit x 8 CPU register file: R0 reads as zero, R7 mirrors the PC, plus a flags register.
// Reads are combinational and writes land on the next clk edge; `REG_FILE_BYPASS_EN forwards IN to matching reads.
// No backpressure: every write and hold request is accepted in the cycle it is presented.
module reg_file_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  RS1,
    input  logic [2:0]  RS2,
    input  logic [2:0]  WS,
    input  logic        WE,
    input  logic [15:0] IN,
    input  logic [15:0] FL_IN,
    input  logic        FL_EN,
    input  logic [15:0] PC_IN,
    input  logic        HE,
    output logic [15:0] OUT1,
    output logic [15:0] OUT2,
    output logic [15:0] PC_S,
    output logic        PC_WE,
    output logic [15:0] FL_OUT
);

    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic [15:0] flags_q;
    logic [15:0] flags_d;
    logic        wr_vld;

    assign wr_vld = WE && (WS != 3'd0);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        // The PC mirror is applied first so an explicit write to R7 overrides it.
        if (HE) begin
            regs_d[7] = PC_IN;
        end
        if (wr_vld) begin
            regs_d[WS] = IN;
        end
        regs_d[0] = 16'h0000;
        flags_d = FL_EN ? FL_IN : flags_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
            flags_q <= 16'h0000;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            flags_q <= flags_d;
        end
    end

    always_comb begin
        OUT1 = regs_q[RS1];
        OUT2 = regs_q[RS2];
        PC_S = regs_q[7];
`ifdef REG_FILE_BYPASS_EN
        if (wr_vld && (RS1 == WS)) begin
            OUT1 = IN;
        end
        if (wr_vld && (RS2 == WS)) begin
            OUT2 = IN;
        end
        if (WE && (WS == 3'd7)) begin
            PC_S = IN;
        end
`endif
    end

    assign PC_WE  = WE && (WS == 3'd7);
    assign FL_OUT = flags_q;

endmodule

// File: tb/tb_reg_file_core.sv
// Bench for reg_file_core: directed register-file scenarios, then random traffic against an array model.
module tb_reg_file_core;

    logic        clk;
    logic        rst_n;
    logic [2:0]  RS1, RS2, WS;
    logic        WE, FL_EN, HE;
    logic [15:0] IN, FL_IN, PC_IN;
    logic [15:0] OUT1, OUT2, PC_S, FL_OUT;
    logic        PC_WE;

    int n_total;
    int n_bad;

    logic [15:0] mdl_reg [8];
    logic [15:0] mdl_fl;

    reg_file_core dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .RS1    (RS1),
        .RS2    (RS2),
        .WS     (WS),
        .WE     (WE),
        .IN     (IN),
        .FL_IN  (FL_IN),
        .FL_EN  (FL_EN),
        .PC_IN  (PC_IN),
        .HE     (HE),
        .OUT1   (OUT1),
        .OUT2   (OUT2),
        .PC_S   (PC_S),
        .PC_WE  (PC_WE),
        .FL_OUT (FL_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_rd(input logic [2:0] sel);
        logic [15:0] v;
        v = (sel == 3'd0) ? 16'h0000 : mdl_reg[sel];
`ifdef REG_FILE_BYPASS_EN
        if (WE && WS != 3'd0 && sel == WS) v = IN;
`endif
        return v;
    endfunction

    function automatic logic [15:0] exp_pc();
        logic [15:0] v;
        v = mdl_reg[7];
`ifdef REG_FILE_BYPASS_EN
        if (WE && WS == 3'd7) v = IN;
`endif
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mdl_reg[i] = 16'h0000;
        mdl_fl = 16'h0000;
    endtask

    // Called at a negedge with inputs already set: check pre-edge outputs, clock, update the model.
    task automatic tick();
        #1;
        chk("out1", OUT1, exp_rd(RS1));
        chk("out2", OUT2, exp_rd(RS2));
        chk("pc_s", PC_S, exp_pc());
        chk("pc_we", {15'd0, PC_WE}, {15'd0, (WE && WS == 3'd7)});
        chk("fl_out", FL_OUT, mdl_fl);
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            if (HE) mdl_reg[7] = PC_IN;
            if (WE && WS != 3'd0) mdl_reg[WS] = IN;
            if (FL_EN) mdl_fl = FL_IN;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        WE = 1'b0; HE = 1'b0; FL_EN = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < 8; r++) begin
            RS1 = r[2:0];
            RS2 = 3'(7 - r);
            #1;
            chk({tag, "_out1"}, OUT1, 16'h0000);
            chk({tag, "_out2"}, OUT2, 16'h0000);
        end
        chk({tag, "_pc_s"}, PC_S, 16'h0000);
        chk({tag, "_fl"}, FL_OUT, 16'h0000);
    endtask

    logic [15:0] wr_val [4];

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n = 1'b0;
        RS1 = 3'd0; RS2 = 3'd0; WS = 3'd0;
        WE = 1'b0; HE = 1'b0; FL_EN = 1'b0;
        IN = 16'h0; FL_IN = 16'h0; PC_IN = 16'h0;
        // Power-up state is unknown, so reset before any comparison.
        HE = 1'b1; FL_EN = 1'b1; WE = 1'b1; WS = 3'd5; IN = 16'h5555; PC_IN = 16'h7777; FL_IN = 16'h3333;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        model_clear();
        idle();
        rst_n = 1'b1;
        check_all_zero("reset");

        // Write to R0 is discarded.
        WE = 1'b1; WS = 3'd0; IN = 16'h1234; RS1 = 3'd0; RS2 = 3'd0;
        tick();
        idle();
        #1;
        chk("r0_out1", OUT1, 16'h0000);
        chk("r0_out2", OUT2, 16'h0000);

        wr_val[0] = 16'h1234; wr_val[1] = 16'hBEEF; wr_val[2] = 16'hDEAD; wr_val[3] = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            WE = 1'b1; WS = 3'(i + 1); IN = wr_val[i]; RS1 = 3'(i + 1);
            #1;
`ifdef REG_FILE_BYPASS_EN
            chk("pre_wr_fwd", OUT1, wr_val[i]);
`else
            chk("pre_wr_old", OUT1, 16'h0000);
`endif
            tick();
        end
        idle();
        RS1 = 3'd4; RS2 = 3'd3;
        #1;
        chk("rd_r4", OUT1, 16'hFFFF);
        chk("rd_r3", OUT2, 16'hDEAD);

        // WE=0 must leave everything untouched.
        IN = 16'hABCD;
        WS = 3'd4; tick();
        WS = 3'd3; tick();
        WS = 3'd1; tick();
        RS1 = 3'd4; RS2 = 3'd3;
        #1;
        chk("we0_r4", OUT1, 16'hFFFF);
        chk("we0_r3", OUT2, 16'hDEAD);
        RS1 = 3'd1;
        #1;
        chk("we0_r1", OUT1, 16'h1234);

        PC_IN = 16'h0005; HE = 1'b0;
        WE = 1'b1; WS = 3'd3; IN = 16'hBADE; tick();
        WS = 3'd1; IN = 16'h0000; tick();
        WS = 3'd4; IN = 16'h0001; tick();
        idle();
        RS1 = 3'd3; RS2 = 3'd1;
        #1;
        chk("ow_r3", OUT1, 16'hBADE);
        chk("ow_r1", OUT2, 16'h0000);
        chk("he0_pc", PC_S, 16'h0000);
        RS2 = 3'd4;
        #1;
        chk("ow_r4", OUT2, 16'h0001);

        HE = 1'b1; PC_IN = 16'h0040; tick();
        idle();
        #1;
        chk("pc_mirror", PC_S, 16'h0040);
        WE = 1'b1; WS = 3'd7; IN = 16'h0100; HE = 1'b1; PC_IN = 16'h0080;
        #1;
        chk("pc_we_hi", {15'd0, PC_WE}, 16'h0001);
        tick();
        idle();
        #1;
        chk("pc_wr_wins", PC_S, 16'h0100);
        chk("pc_we_lo", {15'd0, PC_WE}, 16'h0000);
        FL_EN = 1'b1; FL_IN = 16'h000F; tick();
        idle();
        #1;
        chk("flags", FL_OUT, 16'h000F);

        rst_n = 1'b0; WE = 1'b1; WS = 3'd2; IN = 16'h9999; HE = 1'b1; FL_EN = 1'b1;
        tick();
        idle();
        rst_n = 1'b1;
        check_all_zero("rst2");

        for (int n = 0; n < 500; n++) begin
            rst_n = ($urandom_range(0, 40) != 0);
            RS1   = 3'($urandom_range(0, 7));
            RS2   = 3'($urandom_range(0, 7));
            WS    = 3'($urandom_range(0, 7));
            WE    = ($urandom_range(0, 2) != 0);
            HE    = ($urandom_range(0, 3) == 0);
            FL_EN = ($urandom_range(0, 3) == 0);
            IN    = 16'($urandom);
            FL_IN = 16'($urandom);
            PC_IN = 16'($urandom);
            tick();
        end
        rst_n = 1'b1;
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
